// File: rtl/sprite_loader.sv
// Streams big-endian byte pairs into an internal RGB565 image RAM and serves
// registered, read-first pixel reads to the display side on every cycle.
module sprite_loader #(
  parameter int unsigned DEPTH = 928,
  parameter int unsigned AW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [7:0]    byte_in,
  input  logic          byte_valid,
  output logic          byte_ready,
  input  logic [AW-1:0] count,
  output logic [15:0]   color,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] wr_ptr
);

  typedef enum logic [1:0] {IDLE, HI, LO, FIN} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_wr_ptr;
  logic [7:0]    r_hi;
  logic [15:0]   r_color;
  logic [15:0]   r_mem [DEPTH];

  logic w_xfer;
  logic w_last;
  logic w_we;
  logic w_rd_ok;

  assign w_xfer  = byte_valid & byte_ready;
  assign w_last  = (r_wr_ptr == AW'(DEPTH - 1));
  // A completed word arriving on a reset edge is dropped along with the load.
  assign w_we    = rst_n & w_xfer & (r_state == LO);
  assign w_rd_ok = (32'(count) < DEPTH);

  assign color  = r_color;
  assign wr_ptr = r_wr_ptr;

  always_comb begin
    w_next     = r_state;
    byte_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) w_next = HI;
      end
      HI: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) w_next = LO;
      end
      LO: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) w_next = w_last ? FIN : HI;
      end
      FIN: begin
        done   = 1'b1;
        busy   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_wr_ptr <= '0;
      r_hi     <= '0;
      r_color  <= '0;
    end else begin
      r_state <= w_next;
      r_color <= w_rd_ok ? r_mem[count] : '0;
      if (r_state == IDLE && start) r_wr_ptr <= '0;
      if (r_state == HI && w_xfer) r_hi <= byte_in;
      if (r_state == LO && w_xfer && !w_last) r_wr_ptr <= r_wr_ptr + AW'(1);
    end
  end

  // RAM has no reset; nonblocking write alongside the read gives read-first.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_wr_ptr] <= {r_hi, byte_in};
  end

endmodule

// File: tb/tb_sprite_loader.sv
// Scoreboard bench for sprite_loader: full and stalled loads, boundary reads,
// same-address collision, and abort/restart.
module tb_sprite_loader;
  localparam int DEPTH = 928;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    byte_in = '0;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic [AW-1:0] count = AW'(1000);
  logic [15:0]   color;
  logic          busy;
  logic          done;
  logic [AW-1:0] wr_ptr;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int exp_ptr = 0;
  logic [15:0] model [DEPTH];
  logic [15:0] sb [$];
  int rd_q [$];

  sprite_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .count(count),
    .color(color), .busy(busy), .done(done), .wr_ptr(wr_ptr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall);
    int n;
    n = stall ? $urandom_range(0, 3) : 0;
    for (int i = 0; i < n; i++) begin
      byte_valid = 1'b0;
      tick();
    end
    byte_valid = 1'b1;
    byte_in    = b;
    checks++;
    if (byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_during_load: got %b want 1", byte_ready);
    end
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input bit stall);
    send_byte(w[15:8], stall);
    send_byte(w[7:0], stall);
    model[exp_ptr] = w;
    if (exp_ptr < DEPTH - 1) exp_ptr++;
  endtask

  task automatic begin_load();
    pulse_start();
    exp_ptr = 0;
    checks++;
    if (busy !== 1'b1 || wr_ptr !== '0) begin
      errors++;
      $display("FAIL load_begin: busy=%b wr_ptr=%0d want busy=1 wr_ptr=0", busy, wr_ptr);
    end
  endtask

  // Reads every address in rd_q, one per cycle, against the bench model.
  task automatic read_queue(input string tag);
    logic [15:0] exp;
    int a;
    while (rd_q.size() > 0) begin
      a = rd_q.pop_front();
      count = AW'(a);
      sb.push_back((a < DEPTH) ? model[a] : 16'h0000);
      tick();
      exp = sb.pop_front();
      checks++;
      if (color !== exp) begin
        errors++;
        $display("FAIL %s addr %0d: color=%h want %h", tag, a, color, exp);
      end
    end
  endtask

  task automatic load_image(input logic [15:0] key, input bit stall, input bit beef5);
    logic [15:0] w;
    done_cnt = 0;
    begin_load();
    for (int k = 0; k < DEPTH; k++) begin
      if (stall && k == 50) begin
        pulse_start();
        checks++;
        if (wr_ptr !== AW'(50) || busy !== 1'b1) begin
          errors++;
          $display("FAIL start_ignored: wr_ptr=%0d busy=%b want 50/1", wr_ptr, busy);
        end
      end
      w = (beef5 && k == 5) ? 16'hBEEF : (16'(k) ^ key);
      send_word(w, stall);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || byte_ready !== 1'b0 || wr_ptr !== AW'(DEPTH - 1)) begin
      errors++;
      $display("FAIL fin_state: done=%b busy=%b ready=%b wr_ptr=%0d want 1/1/0/927",
               done, busy, byte_ready, wr_ptr);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || wr_ptr !== AW'(DEPTH - 1) || done_cnt != 1) begin
      errors++;
      $display("FAIL after_fin: done=%b busy=%b wr_ptr=%0d pulses=%0d want 0/0/927/1",
               done, busy, wr_ptr, done_cnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    count = AW'(1000);
    tick();
    tick();
    checks++;
    if (byte_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || wr_ptr !== '0 || color !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state: ready=%b busy=%b done=%b wr_ptr=%0d color=%h want all 0",
               byte_ready, busy, done, wr_ptr, color);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      byte_valid = 1'($urandom_range(0, 1));
      byte_in    = 8'($urandom);
      tick();
      checks++;
      if (byte_ready !== 1'b0 || busy !== 1'b0 || wr_ptr !== '0 || color !== 16'h0000) begin
        errors++;
        $display("FAIL idle_hold cyc %0d: ready=%b busy=%b wr_ptr=%0d color=%h want 0",
                 i, byte_ready, busy, wr_ptr, color);
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic test_full_load();
    load_image(16'hA5A5, 1'b0, 1'b0);
    for (int a = 0; a < DEPTH; a++) rd_q.push_back(a);
    read_queue("full_read");
  endtask

  task automatic test_stalled_load();
    load_image(16'hA5A5, 1'b1, 1'b1);
    for (int a = 0; a < DEPTH; a++) rd_q.push_back(a);
    read_queue("stall_read");
  endtask

  task automatic test_boundary();
    rd_q.push_back(927);
    rd_q.push_back(1000);
    rd_q.push_back(928);
    rd_q.push_back(0);
    rd_q.push_back(1023);
    read_queue("boundary");
  endtask

  task automatic test_collision();
    logic [15:0] exp;
    begin_load();
    for (int k = 0; k < 5; k++) send_word(16'h0100 + 16'(k), 1'b0);
    send_byte(8'h12, 1'b0);
    count      = AW'(5);
    byte_valid = 1'b1;
    byte_in    = 8'h34;
    sb.push_back(model[5]);
    tick();
    byte_valid = 1'b0;
    exp = sb.pop_front();
    checks++;
    if (color !== exp) begin
      errors++;
      $display("FAIL collision_old: color=%h want %h", color, exp);
    end
    model[5] = 16'h1234;
    sb.push_back(model[5]);
    tick();
    exp = sb.pop_front();
    checks++;
    if (color !== exp) begin
      errors++;
      $display("FAIL collision_new: color=%h want %h", color, exp);
    end
  endtask

  task automatic test_abort();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (busy !== 1'b0 || wr_ptr !== '0 || color !== 16'h0000) begin
      errors++;
      $display("FAIL reset_midload: busy=%b wr_ptr=%0d color=%h want 0/0/0000", busy, wr_ptr, color);
    end
    begin_load();
    send_word(16'hA1B2, 1'b0);
    send_byte(8'hC3, 1'b0);
    checks++;
    if (wr_ptr !== AW'(1)) begin
      errors++;
      $display("FAIL three_bytes_ptr: wr_ptr=%0d want 1", wr_ptr);
    end
    byte_valid = 1'b1;
    byte_in    = 8'hD4;
    rst_n      = 1'b0;
    tick();
    rst_n      = 1'b1;
    byte_valid = 1'b0;
    checks++;
    if (wr_ptr !== '0 || busy !== 1'b0 || byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: wr_ptr=%0d busy=%b ready=%b want 0/0/0", wr_ptr, busy, byte_ready);
    end
    rd_q.push_back(1);
    read_queue("abort_discard");
    begin_load();
    send_byte(8'h77, 1'b0);
    pulse_start();
    checks++;
    if (wr_ptr !== '0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_ignored: wr_ptr=%0d busy=%b want 0/1", wr_ptr, busy);
    end
    rd_q.push_back(0);
    read_queue("half_word");
    send_byte(8'h88, 1'b0);
    model[0] = 16'h7788;
    checks++;
    if (wr_ptr !== AW'(1)) begin
      errors++;
      $display("FAIL restart_ptr: wr_ptr=%0d want 1", wr_ptr);
    end
    rd_q.push_back(0);
    read_queue("restart_word");
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_stalled_load();
    test_boundary();
    test_collision();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
